rf_wb_scheduler: RTL

Write-back scheduler for the 32×32 register file in the dynamic pipeline. It shares the file's single write port between NREQ functional-unit result buses using round-robin arbitration and registers the winning result onto the write port. It also keeps a per-register busy scoreboard: issue marks a destination pending, write-back clears it, and the scoreboard blocks WAW issue and tells decode when a source operand is not yet valid.

---
 rtl/rf_sched_pkg.sv | 11 +
 rtl/rr_arbiter.sv | 47 ++++
 rtl/rf_wb_scheduler.sv | 85 ++++++++
 3 files changed

// File: rtl/rf_sched_pkg.sv
// rtl/rf_sched_pkg.sv - shared defaults and constants for the register-file write-back scheduler
package rf_sched_pkg;

   localparam int NREQ_DEF = 4;
   localparam int AW_DEF   = 5;
   localparam int DW_DEF   = 32;

   // Register 0 is hardwired to zero: never tracked as busy, never written.
   localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - rotating-priority arbiter with one-hot grant and encoded winner index
module rr_arbiter #(
   parameter  int NREQ = 4,
   localparam int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [NREQ-1:0] req,
   input  logic            advance,
   output logic [NREQ-1:0] grant,
   output logic [IW-1:0]   grant_idx
);

   logic [IW-1:0] ptr;
   logic [IW-1:0] cand;
   logic          found;
   int            idx;

   // Search from ptr upward (modulo NREQ); the first requester found wins.
   always_comb begin
      grant     = '0;
      grant_idx = '0;
      found     = 1'b0;
      idx       = 0;
      cand      = '0;
      for (int k = 0; k < NREQ; k++) begin
         idx = int'(ptr) + k;
         if (idx >= NREQ) idx = idx - NREQ;
         cand = IW'(idx);
         if (!found && req[cand]) begin
            found     = 1'b1;
            grant_idx = cand;
         end
      end
      if (found) grant[grant_idx] = 1'b1;
   end

   // After a transfer, priority moves to the requester just past the winner.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ptr <= '0;
      end else if (advance) begin
         ptr <= (grant_idx == IW'(NREQ - 1)) ? '0 : IW'(grant_idx + 1'b1);
      end
   end

endmodule

// File: rtl/rf_wb_scheduler.sv
// rtl/rf_wb_scheduler.sv - write-port arbitration and busy scoreboard for the 32x32 register file
module rf_wb_scheduler
   import rf_sched_pkg::*;
#(
   parameter int NREQ = NREQ_DEF,
   parameter int AW   = AW_DEF,
   parameter int DW   = DW_DEF
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [NREQ-1:0]    req_valid,
   input  logic [NREQ*AW-1:0] req_addr,
   input  logic [NREQ*DW-1:0] req_data,
   output logic [NREQ-1:0]    req_ready,
   output logic               rf_rw_ena,
   output logic [AW-1:0]      rf_rw_addr,
   output logic [DW-1:0]      rf_data_rw,
   input  logic               issue_valid,
   input  logic [AW-1:0]      issue_addr,
   output logic               issue_ready,
   input  logic [AW-1:0]      q0_addr,
   input  logic [AW-1:0]      q1_addr,
   output logic               q0_busy,
   output logic               q1_busy,
   output logic [2**AW-1:0]   busy_vec
);

   localparam int            IW        = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam logic [AW-1:0] ZERO_ADDR = AW'(REG_ZERO);

   logic [IW-1:0]     win_idx;
   logic              xfer;
   logic [AW-1:0]     win_addr;
   logic [DW-1:0]     win_data;
   logic [2**AW-1:0]  busy;
   logic [2**AW-1:0]  busy_nxt;

   rr_arbiter #(.NREQ(NREQ)) u_arb (
      .clk       (clk),
      .rst       (rst),
      .req       (req_valid),
      .advance   (xfer),
      .grant     (req_ready),
      .grant_idx (win_idx)
   );

   assign xfer     = |(req_valid & req_ready);
   assign win_addr = req_addr[win_idx*AW +: AW];
   assign win_data = req_data[win_idx*DW +: DW];

   assign issue_ready = issue_valid & ((issue_addr == ZERO_ADDR) | ~busy[issue_addr]);
   assign busy_vec    = busy;
   assign q0_busy     = busy[q0_addr];
   assign q1_busy     = busy[q1_addr];

   // Clear on write-back first, then set on issue, so a same-register collision leaves the bit set.
   always_comb begin
      busy_nxt = busy;
      if (xfer && (win_addr != ZERO_ADDR)) busy_nxt[win_addr] = 1'b0;
      if (issue_ready && (issue_addr != ZERO_ADDR)) busy_nxt[issue_addr] = 1'b1;
      busy_nxt[0] = 1'b0;
   end

   // Scoreboard register; reset drops every pending destination.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) busy <= '0;
      else      busy <= busy_nxt;
   end

   // Register the winning result onto the write port; writes to register 0 are suppressed.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rf_rw_ena  <= 1'b0;
         rf_rw_addr <= '0;
         rf_data_rw <= '0;
      end else if (xfer) begin
         rf_rw_ena  <= (win_addr != ZERO_ADDR);
         rf_rw_addr <= win_addr;
         rf_data_rw <= win_data;
      end else begin
         rf_rw_ena  <= 1'b0;
      end
   end

endmodule
